uart_transmitter: RTL and testbench

- Parallel-to-serial UART transmitter, 8N1, LSB first, line idles high.
- Pairs with the existing receiver (same CLKS_PER_BIT convention, same state flow) to form the full UART.
- One-byte holding register with a ready/load handshake, so the next byte can be queued while the current frame is on the line.
- Sits between the user logic and the serial output pin.

---
 rtl/uart_transmitter.sv | 153 +++++++++++++++
 tb/tb_uart_transmitter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one-byte holding register with ready/load handshake, LSB first, line idles high.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined (sense from PARITY_ODD).
module uart_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] dataIn,
   input  logic       dataLoad,
   output logic       ready,
   output logic       serialOut,
   output logic       txActive,
   output logic       txDone
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_transmitter: CLKS_PER_BIT must be 2..65535 and PARITY_ODD 0 or 1");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
      ,S_PARITY = 3'd5
`endif
   } state_e;

   state_e              state_q;
   logic [DATA_W-1:0]   hold_q;
   logic [DATA_W-1:0]   shift_q;
   logic [IDX_W-1:0]    bit_idx_q;
   logic [CNT_W-1:0]    clk_cnt_q;
   logic                ready_q;
   logic                serial_q;
   logic                active_q;
   logic                done_q;

   // Line outputs are registered from the state held during the cycle, so they lag the state by one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         clk_cnt_q <= '0;
         ready_q   <= 1'b1;
         serial_q  <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (!ready_q) begin
                  shift_q   <= hold_q;
                  ready_q   <= 1'b1;
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  state_q   <= S_START;
               end
            end

            S_START: begin
               serial_q <= 1'b0;
               active_q <= 1'b1;
               if (clk_cnt_q == LAST_CNT) begin
                  clk_cnt_q <= '0;
                  state_q   <= S_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end

            S_DATA: begin
               serial_q <= shift_q[bit_idx_q];
               active_q <= 1'b1;
               if (clk_cnt_q == LAST_CNT) begin
                  clk_cnt_q <= '0;
                  if (bit_idx_q == LAST_IDX) begin
                     bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                     state_q   <= S_PARITY;
`else
                     state_q   <= S_STOP;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + IDX_W'(1);
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               serial_q <= (^shift_q) ^ (PARITY_ODD != 0);
               active_q <= 1'b1;
               if (clk_cnt_q == LAST_CNT) begin
                  clk_cnt_q <= '0;
                  state_q   <= S_STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
`endif

            S_STOP: begin
               active_q <= 1'b1;
               if (clk_cnt_q == LAST_CNT) begin
                  clk_cnt_q <= '0;
                  state_q   <= S_CLEANUP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end

            S_CLEANUP: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase

         // IDLE only drains the holding register while ready_q is low, so the two never collide.
         if (dataLoad && ready_q) begin
            hold_q  <= dataIn;
            ready_q <= 1'b0;
         end
      end
   end

   assign ready     = ready_q;
   assign serialOut = serial_q;
   assign txActive  = active_q;
   assign txDone    = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at CLKS_PER_BIT=4: queue-based line model checked every cycle,
// plus directed literal checks (single byte, back-to-back, overrun, reset mid-frame, parity build).
module tb_uart_transmitter;

   localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS        = 11;
   localparam int          FRAME_CYC    = 44;
   localparam int          START_SPACE  = 46;
`else
   localparam int unsigned NBITS        = 10;
   localparam int          FRAME_CYC    = 40;
   localparam int          START_SPACE  = 42;
`endif

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic [7:0] data_in   = 8'h00;
   logic       data_load = 1'b0;
   logic       ready;
   logic       serial_out;
   logic       tx_active;
   logic       tx_done;

   int total = 0;
   int bad   = 0;

   uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dataIn    (data_in),
      .dataLoad  (data_load),
      .ready     (ready),
      .serialOut (serial_out),
      .txActive  (tx_active),
      .txDone    (tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic ser;
      logic act;
      logic done;
   } line_t;

   line_t      exp_q[$];
   line_t      m_exp   = '{1'b1, 1'b0, 1'b0};
   logic       m_ready = 1'b1;
   logic [7:0] m_hold  = 8'h00;

   // Frame bits in transmit order: start, d0..d7, [even parity], stop.
   function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
      logic [NBITS-1:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ^b;
`endif
      return f;
   endfunction

   // Each edge: emit the next queued line value; an empty queue means the line is free to start the held byte.
   always @(posedge clk) begin : model
      logic             take;
      logic [NBITS-1:0] fb;
      if (!rst_n) begin
         exp_q.delete();
         m_ready = 1'b1;
         m_exp   = '{1'b1, 1'b0, 1'b0};
      end else begin
         take = data_load && m_ready;
         if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
         end else begin
            m_exp = '{1'b1, 1'b0, 1'b0};
            if (!m_ready) begin
               fb = frame_bits(m_hold);
               for (int i = 0; i < int'(NBITS); i++)
                  for (int k = 0; k < int'(CPB); k++) exp_q.push_back('{fb[i], 1'b1, 1'b0});
               exp_q.push_back('{1'b1, 1'b0, 1'b1});
               m_ready = 1'b1;
            end
         end
         if (take) begin
            m_hold  = data_in;
            m_ready = 1'b0;
         end
      end
   end

   always @(negedge clk) begin : compare
      check("ready",     ready,      m_ready);
      check("serialOut", serial_out, m_exp.ser);
      check("txActive",  tx_active,  m_exp.act);
      check("txDone",    tx_done,    m_exp.done);
   end

   // ---------------- txActive edge recorder ----------------
   int   cyc      = 0;
   logic prev_act = 1'b0;
   int   rise_q[$];
   int   fall_q[$];

   always @(negedge clk) begin : recorder
      cyc++;
      if (tx_active === 1'b1 && prev_act !== 1'b1) rise_q.push_back(cyc);
      if (tx_active !== 1'b1 && prev_act === 1'b1) fall_q.push_back(cyc);
      prev_act = tx_active;
   end

   // ---------------- stimulus helpers ----------------
   logic rx_bits[NBITS];

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] b);
      data_in   = b;
      data_load = 1'b1;
      @(negedge clk);
      data_load = 1'b0;
      data_in   = 8'($urandom);
   endtask

   task automatic wait_active();
      int n = 0;
      while (tx_active !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n > 500) begin
            check("active_timeout", 0, 1);
            return;
         end
      end
   endtask

   // Mid-bit sampling receiver; returns at the stop-bit sample.
   task automatic rx_byte(output logic [7:0] b);
      int n = 0;
      b = 8'h00;
      while (serial_out !== 1'b0) begin
         @(negedge clk);
         n++;
         if (n > 2000) begin
            check("rx_start_timeout", 0, 1);
            return;
         end
      end
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < int'(NBITS); i++) begin
         rx_bits[i] = serial_out;
         if (i >= 1 && i <= 8) b[3'(i-1)] = serial_out;
         if (i < int'(NBITS) - 1) repeat (CPB) @(negedge clk);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] b0;
      logic [7:0] b1;
      int         act_cnt;
      int         lit_a5[9];
      lit_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1};

      // Reset
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      check("rst_ready",  ready,      1);
      check("rst_serial", serial_out, 1);
      check("rst_active", tx_active,  0);
      check("rst_done",   tx_done,    0);
      act_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         if (serial_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) act_cnt++;
         tick(1);
      end
      check("idle_activity", act_cnt, 0);

      // Single byte 0xA5
      rise_q.delete();
      fall_q.delete();
      load(8'hA5);
      rx_byte(b0);
      check("a5_decode", b0, 8'hA5);
      for (int i = 0; i < 9; i++) check("a5_bit", rx_bits[i], lit_a5[i]);
      check("a5_stop", rx_bits[NBITS-1], 1);
      tick(1);
      check("a5_done_early", tx_done, 0);
      tick(1);
      check("a5_done_pulse", tx_done, 1);
      tick(1);
      check("a5_done_width", tx_done, 0);
      tick(2);
      if (rise_q.size() == 1 && fall_q.size() == 1)
         check("a5_frame_len", fall_q[0] - rise_q[0], FRAME_CYC);
      else
         check("a5_active_edges", rise_q.size() * 16 + fall_q.size(), 17);

      // Back-to-back 0x00 then 0xFF, with an overrun attempt of 0x3C
      rise_q.delete();
      fall_q.delete();
      fork
         begin
            rx_byte(b0);
            rx_byte(b1);
         end
         begin
            load(8'h00);
            wait_active();
            tick(5);
            check("b2b_ready_mid", ready, 1);
            load(8'hFF);
            check("b2b_ready_queued", ready, 0);
            load(8'h3C);
            check("overrun_ready", ready, 0);
         end
      join
      check("b2b_first",  b0, 8'h00);
      check("b2b_second", b1, 8'hFF);
      tick(60);
      check("overrun_frames", rise_q.size(), 2);
      if (rise_q.size() >= 2) check("b2b_spacing", rise_q[1] - rise_q[0], START_SPACE);

      // Reset during data bit 3 of 0x55
      load(8'h55);
      wait_active();
      tick(17);
      check("rst_mid_line_low", serial_out, 0);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("rst_mid_serial", serial_out, 1);
      check("rst_mid_ready",  ready,      1);
      check("rst_mid_active", tx_active,  0);
      act_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (tx_done === 1'b1 || tx_active === 1'b1) act_cnt++;
         tick(1);
      end
      check("rst_mid_quiet", act_cnt, 0);
      load(8'h81);
      rx_byte(b0);
      check("after_rst_decode", b0, 8'h81);
      tick(4);

`ifdef UART_TX_PARITY_EN
      load(8'h07);
      rx_byte(b0);
      check("par07_decode", b0, 8'h07);
      check("par07_bit", rx_bits[9], 1);
      tick(3);
      load(8'h03);
      rx_byte(b0);
      check("par03_decode", b0, 8'h03);
      check("par03_bit", rx_bits[9], 0);
      tick(3);
`endif

      // Randomized loads at random gaps; dropped loads and dataIn churn checked by the model
      for (int k = 0; k < 40; k++) begin
         tick($urandom_range(0, 45));
         load(8'($urandom));
      end
      tick(2 * int'(NBITS * CPB) + 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
